// File: rtl/div_unit.sv
// rtl/div_unit.sv - 32-bit restoring radix-2 divider (DIV/DIVU), hilo result layout
module div_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        signed_div,
  input  logic        start,
  input  logic        cancel,
  output logic [63:0] res,
  output logic        ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [63:0] res_q, res_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;

  logic [32:0] trial, diff;
  logic        take;
  logic [31:0] rem_nx, quo_nx;
  logic [31:0] abs_a, abs_b;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
    ready_d = 1'b0;

    // quo_q starts as the dividend magnitude and shifts out MSB-first while quotient bits shift in
    trial  = {rem_q, quo_q[31]};
    diff   = trial - {1'b0, dvs_q};
    take   = ~diff[32];
    rem_nx = take ? diff[31:0] : trial[31:0];
    quo_nx = {quo_q[30:0], take};

    abs_a = (signed_div && A[31]) ? -A : A;
    abs_b = (signed_div && B[31]) ? -B : B;

    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          quo_d  = abs_a;
          dvs_d  = abs_b;
          rem_d  = 32'd0;
          cnt_d  = 5'd0;
          qneg_d = signed_div && (A[31] ^ B[31]);
          rneg_d = signed_div && A[31];
          if (B == 32'd0) begin
            state_d = DONE;
            res_d   = {A, 32'hFFFF_FFFF};
            ready_d = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = DONE;
          ready_d = 1'b1;
          res_d   = {(rneg_q ? -rem_nx : rem_nx), (qneg_q ? -quo_nx : quo_nx)};
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (cancel) begin
      state_d = IDLE;
      cnt_d   = 5'd0;
      res_d   = res_q;
      ready_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= 64'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign res   = res_q;
  assign ready = ready_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit: timing model plus directed vectors
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        signed_div = 1'b0;
  logic        start = 1'b0;
  logic        cancel = 1'b0;
  logic [63:0] res;
  logic        ready;
  logic        busy;

  int checks = 0;
  int failures = 0;

  div_unit dut (
    .clk(clk), .resetn(resetn), .A(A), .B(B), .signed_div(signed_div),
    .start(start), .cancel(cancel), .res(res), .ready(ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint x, y, q, r;
    int     ai, bi;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      ai = a; bi = b;
      x = ai; y = bi;
    end else begin
      x = {32'd0, a}; y = {32'd0, b};
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // Model: result becomes visible a fixed number of edges after acceptance
  logic [63:0] m_res = 64'd0, m_pend = 64'd0;
  logic        m_busy = 1'b0, m_ready = 1'b0;
  int          m_left = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_res = 64'd0; m_busy = 1'b0; m_ready = 1'b0; m_left = 0;
    end else if (cancel) begin
      m_busy = 1'b0; m_ready = 1'b0; m_left = 0;
    end else if (m_ready) begin
      m_ready = 1'b0; m_busy = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_ready = 1'b1;
        m_res   = m_pend;
      end
    end else if (start) begin
      m_busy = 1'b1;
      m_pend = ref_div(A, B, signed_div);
      if (B == 32'd0) begin
        m_ready = 1'b1;
        m_res   = m_pend;
      end else begin
        m_left = 32;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_busy", {63'd0, busy}, {63'd0, m_busy});
    check("cyc_ready", {63'd0, ready}, {63'd0, m_ready});
    check("cyc_res", res, m_res);
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [63:0] exp, input int exp_lat);
    int lat = 0;
    int busy_cnt = 0;
    bit got = 0;
    check("model_pin", ref_div(a, b, s), exp);
    @(posedge clk); #2;
    A = a; B = b; signed_div = s; start = 1'b1;
    while (!got && lat < 100) begin
      @(posedge clk);
      lat++;
      if (lat == 1) begin
        #2;
        start = 1'b0;
        A = $urandom; B = $urandom; signed_div = ~s;
      end
      @(negedge clk);
      if (lat == 1) check("busy_after_accept", {63'd0, busy}, 64'd1);
      if (busy) busy_cnt++;
      if (ready) got = 1;
    end
    check("ready_latency", lat, exp_lat);
    check("busy_cycles", busy_cnt, exp_lat);
    check("res_literal", res, exp);
  endtask

  task automatic watch_no_ready(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ready) seen++;
    end
    check(name, seen, 0);
  endtask

  initial begin
    #1 resetn = 1'b0;
    #1;
    check("reset_res", res, 64'd0);
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;

    run_op(32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E}, 33);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h8000_0000}, 33);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h8000_0000, 32'h0000_0000}, 33);
    run_op(32'd5, 32'd0, 1'b0, {32'h0000_0005, 32'hFFFF_FFFF}, 1);
    run_op(32'd5, 32'd0, 1'b1, {32'h0000_0005, 32'hFFFF_FFFF}, 1);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, {32'h0000_0000, 32'hFFFF_FFFF}, 33);
    run_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, {32'hFFFF_FFFE, 32'h0000_000E}, 33);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, {32'h0000_0000, 32'h0000_0001}, 33);

    // Cancel at iteration 10 alongside a competing start; an earlier mid-CALC start is ignored
    @(posedge clk); #2;
    A = 32'd100; B = 32'd7; signed_div = 1'b0; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; A = 32'h0001_2345; B = 32'd3;
    repeat (3) @(posedge clk); #2;
    start = 1'b1; A = 32'd9; B = 32'd2;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (6) @(posedge clk); #2;
    cancel = 1'b1; start = 1'b1; A = 32'd50; B = 32'd3;
    @(posedge clk); #2;
    cancel = 1'b0; start = 1'b0;
    @(negedge clk);
    check("cancel_busy", {63'd0, busy}, 64'd0);
    check("cancel_res_kept", res, {32'h0000_0000, 32'h0000_0001});
    watch_no_ready("no_ready_after_cancel", 40);

    // Asynchronous reset mid-CALC
    @(posedge clk); #2;
    A = 32'd100; B = 32'd7; signed_div = 1'b0; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_res", res, 64'd0);
    check("async_rst_ready", {63'd0, ready}, 64'd0);
    check("async_rst_busy", {63'd0, busy}, 64'd0);
    #4 resetn = 1'b1;
    watch_no_ready("no_ready_after_reset", 40);

    run_op(32'd100, 32'd7, 1'b0, {32'h0000_0002, 32'h0000_000E}, 33);
    run_op(32'd5, 32'd0, 1'b1, {32'h0000_0005, 32'hFFFF_FFFF}, 1);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
